// File: rtl/risc_ctrl_fsm.sv
// Instruction sequencer for the 8-bit accumulator RISC CPU.
// Steps each instruction through IDLE -> S0..S7 and drives the bus and
// register-load strobes. S0..S3 fetch the instruction, S4..S7 execute it.
// Every strobe is registered. Each strobe is decoded from the state being
// entered and from the opcode/zero values present at that clock edge.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   ena          run enable; low abandons the current instruction
//   opcode       IR[7:5], opcode of the current instruction
//   zero         ALU zero flag
//   rd, wr       memory read / write strobes
//   load_ir      load IR from the data bus
//   inc_pc       increment PC
//   load_pc      load PC from the IR address field
//   load_acc     load accumulator from the ALU output
//   datactl_ena  drive the accumulator onto the data bus
//   halt         sticky halted flag
//   fetch        high during S0..S3
//   instr_done   one-cycle pulse in S7
//   state        current state code (debug)
module risc_ctrl_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       rd,
  output logic       wr,
  output logic       load_ir,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       datactl_ena,
  output logic       halt,
  output logic       fetch,
  output logic       instr_done,
  output logic [3:0] state
);

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_HLT  = 3'b000;
  localparam logic [OP_W-1:0] OP_SKZ  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OP_W-1:0] OP_ANDD = 3'b011;
  localparam logic [OP_W-1:0] OP_XORR = 3'b100;
  localparam logic [OP_W-1:0] OP_LDA  = 3'b101;
  localparam logic [OP_W-1:0] OP_STO  = 3'b110;
  localparam logic [OP_W-1:0] OP_JMP  = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_S0     = 4'd1,
    ST_S1     = 4'd2,
    ST_S2     = 4'd3,
    ST_S3     = 4'd4,
    ST_S4     = 4'd5,
    ST_S5     = 4'd6,
    ST_S6     = 4'd7,
    ST_S7     = 4'd8,
    ST_HALTED = 4'd9
  } state_t;

  state_t state_q;
  state_t state_d;

  logic rd_d;
  logic wr_d;
  logic load_ir_d;
  logic inc_pc_d;
  logic load_pc_d;
  logic load_acc_d;
  logic datactl_ena_d;
  logic halt_d;
  logic fetch_d;
  logic instr_done_d;

  // Opcode classes used by the execute-phase decode
  logic op_alu;
  logic op_skz;
  logic op_sto;
  logic op_jmp;

  always_comb begin
    op_alu = (opcode == OP_ADD) || (opcode == OP_ANDD) ||
             (opcode == OP_XORR) || (opcode == OP_LDA);
    op_skz = (opcode == OP_SKZ);
    op_sto = (opcode == OP_STO);
    op_jmp = (opcode == OP_JMP);
  end

  // State register and registered strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rd          <= 1'b0;
      wr          <= 1'b0;
      load_ir     <= 1'b0;
      inc_pc      <= 1'b0;
      load_pc     <= 1'b0;
      load_acc    <= 1'b0;
      datactl_ena <= 1'b0;
      halt        <= 1'b0;
      fetch       <= 1'b0;
      instr_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd          <= rd_d;
      wr          <= wr_d;
      load_ir     <= load_ir_d;
      inc_pc      <= inc_pc_d;
      load_pc     <= load_pc_d;
      load_acc    <= load_acc_d;
      datactl_ena <= datactl_ena_d;
      halt        <= halt_d;
      fetch       <= fetch_d;
      instr_done  <= instr_done_d;
    end
  end

  // Next state, then the strobe pattern of the state being entered
  always_comb begin
    state_d       = state_q;
    rd_d          = 1'b0;
    wr_d          = 1'b0;
    load_ir_d     = 1'b0;
    inc_pc_d      = 1'b0;
    load_pc_d     = 1'b0;
    load_acc_d    = 1'b0;
    datactl_ena_d = 1'b0;
    halt_d        = 1'b0;
    fetch_d       = 1'b0;
    instr_done_d  = 1'b0;

    // ena is tested before the HLT decode so an abort wins in S3
    case (state_q)
      ST_IDLE:   state_d = ena ? ST_S0 : ST_IDLE;
      ST_S0:     state_d = ena ? ST_S1 : ST_IDLE;
      ST_S1:     state_d = ena ? ST_S2 : ST_IDLE;
      ST_S2:     state_d = ena ? ST_S3 : ST_IDLE;
      ST_S3: begin
        if (!ena)                  state_d = ST_IDLE;
        else if (opcode == OP_HLT) state_d = ST_HALTED;
        else                       state_d = ST_S4;
      end
      ST_S4:     state_d = ena ? ST_S5 : ST_IDLE;
      ST_S5:     state_d = ena ? ST_S6 : ST_IDLE;
      ST_S6:     state_d = ena ? ST_S7 : ST_IDLE;
      ST_S7:     state_d = ena ? ST_S0 : ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_S0: begin
        rd_d      = 1'b1;
        load_ir_d = 1'b1;
        fetch_d   = 1'b1;
      end
      ST_S1: begin
        rd_d      = 1'b1;
        load_ir_d = 1'b1;
        inc_pc_d  = 1'b1;
        fetch_d   = 1'b1;
      end
      ST_S2: begin
        fetch_d = 1'b1;
      end
      ST_S3: begin
        inc_pc_d = 1'b1;
        fetch_d  = 1'b1;
      end
      ST_S4: begin
        rd_d          = op_alu;
        load_pc_d     = op_jmp;
        datactl_ena_d = op_sto;
      end
      ST_S5: begin
        rd_d          = op_alu;
        load_acc_d    = op_alu;
        load_pc_d     = op_jmp;
        inc_pc_d      = op_jmp || (op_skz && zero);
        datactl_ena_d = op_sto;
      end
      ST_S6: begin
        rd_d          = op_alu;
        wr_d          = op_sto;
        datactl_ena_d = op_sto;
      end
      ST_S7: begin
        instr_done_d = 1'b1;
        inc_pc_d     = op_skz && zero;
      end
      ST_HALTED: begin
        halt_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// Self-checking bench for risc_ctrl_fsm. Each stimulus cycle pushes the
// expected output vector onto a scoreboard queue; a monitor pops and
// compares one entry per rising edge, 1 time unit after the edge.
module tb_risc_ctrl_fsm;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;
  logic       rd, wr, load_ir, inc_pc, load_pc, load_acc;
  logic       datactl_ena, halt, fetch, instr_done;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  // Strobe bit positions: {rd,wr,load_ir,inc_pc,load_pc,load_acc,dctl,halt,fetch,done}
  localparam logic [9:0] B_RD   = 10'b1000000000;
  localparam logic [9:0] B_WR   = 10'b0100000000;
  localparam logic [9:0] B_IR   = 10'b0010000000;
  localparam logic [9:0] B_INC  = 10'b0001000000;
  localparam logic [9:0] B_LPC  = 10'b0000100000;
  localparam logic [9:0] B_LACC = 10'b0000010000;
  localparam logic [9:0] B_DCTL = 10'b0000001000;
  localparam logic [9:0] B_HALT = 10'b0000000100;
  localparam logic [9:0] B_FET  = 10'b0000000010;
  localparam logic [9:0] B_DONE = 10'b0000000001;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, ANDD = 3'b011;
  localparam logic [2:0] XORR = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

  logic [13:0] exp_q[$];
  string       tag_q[$];

  risc_ctrl_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .opcode      (opcode),
    .zero        (zero),
    .rd          (rd),
    .wr          (wr),
    .load_ir     (load_ir),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .load_acc    (load_acc),
    .datactl_ena (datactl_ena),
    .halt        (halt),
    .fetch       (fetch),
    .instr_done  (instr_done),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] mk(input logic [3:0] st, input logic [9:0] s);
    return {s, st};
  endfunction

  // Expected vector for step k (0..7) of an instruction
  function automatic logic [13:0] instr_vec(input int k, input logic [2:0] op, input logic z);
    logic alu;
    alu = (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
    case (k)
      0: return mk(4'd1, B_RD | B_IR | B_FET);
      1: return mk(4'd2, B_RD | B_IR | B_INC | B_FET);
      2: return mk(4'd3, B_FET);
      3: return mk(4'd4, B_INC | B_FET);
      4: begin
        if (alu)       return mk(4'd5, B_RD);
        if (op == JMP) return mk(4'd5, B_LPC);
        if (op == STO) return mk(4'd5, B_DCTL);
        return mk(4'd5, 10'd0);
      end
      5: begin
        if (alu)       return mk(4'd6, B_RD | B_LACC);
        if (op == JMP) return mk(4'd6, B_LPC | B_INC);
        if (op == STO) return mk(4'd6, B_DCTL);
        if (op == SKZ && z) return mk(4'd6, B_INC);
        return mk(4'd6, 10'd0);
      end
      6: begin
        if (alu)       return mk(4'd7, B_RD);
        if (op == STO) return mk(4'd7, B_WR | B_DCTL);
        return mk(4'd7, 10'd0);
      end
      default: begin
        if (op == SKZ && z) return mk(4'd8, B_DONE | B_INC);
        return mk(4'd8, B_DONE);
      end
    endcase
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic step(input logic r, input logic e, input logic [2:0] op,
                      input logic z, input logic [13:0] exp, input string tag);
    @(negedge clk);
    rst_n  = r;
    ena    = e;
    opcode = op;
    zero   = z;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z, input string name);
    for (int k = 0; k < 8; k++)
      step(1'b1, 1'b1, op, z, instr_vec(k, op, z), $sformatf("%s_s%0d", name, k));
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [13:0] got;
      string       t;
      logic [13:0] e;
      got = {rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena,
             halt, fetch, instr_done, state};
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, got, e);
      chk({t, "_rdwr_excl"}, 14'(rd & wr), 14'd0);
      chk({t, "_wr_dctl"}, 14'(wr & ~datactl_ena), 14'd0);
    end
  end

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    opcode = ADD;
    zero   = 1'b0;

    step(1'b0, 1'b1, ADD, 1'b0, 14'd0, "reset0");
    step(1'b0, 1'b1, ADD, 1'b0, 14'd0, "reset1");

    // Release: first S0 comes straight out of reset
    run_instr(ADD, 1'b0, "add");
    run_instr(STO, 1'b0, "sto");
    run_instr(SKZ, 1'b1, "skz_z1");
    run_instr(SKZ, 1'b0, "skz_z0");
    run_instr(LDA, 1'b1, "lda");
    run_instr(JMP, 1'b0, "jmp");

    // JMP abort: ena low while in S5
    for (int k = 0; k < 6; k++)
      step(1'b1, 1'b1, JMP, 1'b0, instr_vec(k, JMP, 1'b0), $sformatf("jmpab_s%0d", k));
    step(1'b1, 1'b0, JMP, 1'b0, 14'd0, "jmp_abort");
    step(1'b1, 1'b0, JMP, 1'b0, 14'd0, "idle_hold");

    // HLT with ena low at the S3 edge: abort wins
    for (int k = 0; k < 4; k++)
      step(1'b1, 1'b1, HLT, 1'b0, instr_vec(k, HLT, 1'b0), $sformatf("hltab_s%0d", k));
    step(1'b1, 1'b0, HLT, 1'b0, 14'd0, "hlt_abort");

    // HLT proper, then halted for 20 cycles regardless of ena
    for (int k = 0; k < 4; k++)
      step(1'b1, 1'b1, HLT, 1'b0, instr_vec(k, HLT, 1'b0), $sformatf("hlt_s%0d", k));
    step(1'b1, 1'b1, HLT, 1'b0, mk(4'd9, B_HALT), "halted");
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), mk(4'd9, B_HALT), $sformatf("halted_%0d", i));

    // Reset leaves HALTED
    step(1'b0, 1'b1, ADD, 1'b0, 14'd0, "halt_reset");
    step(1'b1, 1'b0, ADD, 1'b0, 14'd0, "idle_after_reset");
    run_instr(XORR, 1'b0, "xorr");

    // Drain with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) chk("drain", 14'(exp_q.size()), 14'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
